// File: rtl/ball_ctrl_pkg.sv
// Shared pong constants: screen limits, paddle geometry, game rules, FSM encoding.
package ball_ctrl_pkg;

    localparam int unsigned POS_W   = 11;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned HOLD_W  = 7;

    localparam logic [POS_W-1:0] V_MIN   = 11'd8;
    localparam logic [POS_W-1:0] V_MAX   = 11'd592;
    localparam logic [POS_W-1:0] H_MIN   = 11'd8;
    localparam logic [POS_W-1:0] H_MAX   = 11'd792;
    localparam logic [POS_W-1:0] PAD_L_H = 11'd24;
    localparam logic [POS_W-1:0] PAD_R_H = 11'd776;
    localparam logic [POS_W:0]   PAD_LEN = 12'd80;

    localparam logic [HOLD_W-1:0]  HOLD = 7'd120;
    localparam logic [SCORE_W-1:0] WIN  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    // Ball row inside paddle span; pad+PAD_LEN is widened so a low paddle cannot wrap.
    function automatic logic in_span(input logic [POS_W-1:0] pad, input logic [POS_W-1:0] v);
        logic [POS_W:0] v_w;
        logic [POS_W:0] pad_w;
        v_w   = {1'b0, v};
        pad_w = {1'b0, pad};
        return (v_w >= pad_w) && (v_w < (pad_w + PAD_LEN));
    endfunction

    // Score increment that stops at the winning value.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/ball_ctrl_if.sv
// Ball controller bus: positions in, direction/game status out.
interface ball_ctrl_if;
    import ball_ctrl_pkg::*;

    logic                 start;
    logic [POS_W-1:0]     v_pos;
    logic [POS_W-1:0]     h_pos;
    logic [POS_W-1:0]     pad_l_v;
    logic [POS_W-1:0]     pad_r_v;
    logic                 dh;
    logic                 dv;
    logic                 pause;
    logic                 serve;
    logic [SCORE_W-1:0]   score_l;
    logic [SCORE_W-1:0]   score_r;
    logic                 hit;

    modport master (
        output start, v_pos, h_pos, pad_l_v, pad_r_v,
        input  dh, dv, pause, serve, score_l, score_r, hit
    );

    modport slave (
        input  start, v_pos, h_pos, pad_l_v, pad_r_v,
        output dh, dv, pause, serve, score_l, score_r, hit
    );

endinterface

// File: rtl/ball_ctrl_hold_timer.sv
// Loadable down-counter timing the pause after a missed ball.
module ball_ctrl_hold_timer
    import ball_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              done_c
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    // Load has priority; otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 7'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: bounces, paddle hits, misses, scoring and serve sequencing.
module ball_ctrl
    import ball_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ball_ctrl_if.slave  bus
);

    // Timer reaches zero on the HOLD-th cycle spent in MISS.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD - 7'd1;

    state_e               state_q, state_d;
    logic                 dh_q, dh_d;
    logic                 dv_q, dv_d;
    logic                 pause_q, pause_d;
    logic                 serve_q, serve_d;
    logic                 hit_q, hit_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;
    logic                 hold_load_c;
    logic                 hold_done_c;

    ball_ctrl_hold_timer u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load_c),
        .load_val (HOLD_LOAD),
        .done_c   (hold_done_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        dh_d        = dh_q;
        dv_d        = dv_q;
        pause_d     = pause_q;
        serve_d     = 1'b0;
        hit_d       = 1'b0;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_load_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pause_d = 1'b1;
                if (bus.start) begin
                    serve_d = 1'b1;
                    pause_d = 1'b0;
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                pause_d = 1'b0;
                // Vertical walls, independent of the horizontal checks.
                if (!dv_q && (bus.v_pos <= V_MIN)) begin
                    dv_d = 1'b1;
                end else if (dv_q && (bus.v_pos >= V_MAX)) begin
                    dv_d = 1'b0;
                end
                // Horizontal: a miss outranks a paddle hit.
                if (!dh_q && (bus.h_pos <= H_MIN)) begin
                    score_r_d   = sat_inc(score_r_q);
                    pause_d     = 1'b1;
                    hold_load_c = 1'b1;
                    state_d     = ST_MISS;
                end else if (dh_q && (bus.h_pos >= H_MAX)) begin
                    score_l_d   = sat_inc(score_l_q);
                    pause_d     = 1'b1;
                    hold_load_c = 1'b1;
                    state_d     = ST_MISS;
                end else if (!dh_q && (bus.h_pos <= PAD_L_H) && in_span(bus.pad_l_v, bus.v_pos)) begin
                    dh_d  = 1'b1;
                    hit_d = 1'b1;
                end else if (dh_q && (bus.h_pos >= PAD_R_H) && in_span(bus.pad_r_v, bus.v_pos)) begin
                    dh_d  = 1'b0;
                    hit_d = 1'b1;
                end
            end

            ST_MISS: begin
                pause_d = 1'b1;
                if (hold_done_c) begin
                    if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                        state_d = ST_OVER;
                    end else begin
                        // dh still holds the direction of the missed ball; serve
                        // back the other way, toward the player who won the point.
                        dh_d    = ~dh_q;
                        dv_d    = 1'b0;
                        serve_d = 1'b1;
                        pause_d = 1'b0;
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_OVER: begin
                pause_d = 1'b1;
                if (bus.start) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    dh_d      = 1'b1;
                    dv_d      = 1'b0;
                    serve_d   = 1'b1;
                    pause_d   = 1'b0;
                    state_d   = ST_PLAY;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pause_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dh_q      <= 1'b1;
            dv_q      <= 1'b0;
            pause_q   <= 1'b1;
            serve_q   <= 1'b0;
            hit_q     <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
        end else begin
            state_q   <= state_d;
            dh_q      <= dh_d;
            dv_q      <= dv_d;
            pause_q   <= pause_d;
            serve_q   <= serve_d;
            hit_q     <= hit_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign bus.dh      = dh_q;
    assign bus.dv      = dv_q;
    assign bus.pause   = pause_q;
    assign bus.serve   = serve_q;
    assign bus.hit     = hit_q;
    assign bus.score_l = score_l_q;
    assign bus.score_r = score_r_q;

endmodule
